// File: rtl/code_entry_ctrl_pkg.sv
// Shared types and constants for the keypad code entry controller.
// Holds state encoding, digit width and default durations.
package code_entry_ctrl_pkg;

    localparam int DIGIT_W = 4;

    localparam int DEF_DIGITS   = 4;
    localparam int DEF_TIMEOUT  = 50_000_000;
    localparam int DEF_HOLD     = 25_000_000;
    localparam int DEF_MAX_FAIL = 3;
    localparam int DEF_LOCK     = 250_000_000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_CHECK   = 3'd2,
        ST_GRANT   = 3'd3,
        ST_DENY    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/code_entry_ctrl_cycle_timer.sv
// Loadable down-counter shared by timeout, hold and lockout durations.
// Ports: clk, rst (sync, active-low), load_i/load_val_i, value_o, expired_o.
module code_entry_ctrl_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] value_o,
    output logic         expired_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Counts down freely and parks at zero; a load always wins.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o   = cnt_q;
    assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/code_entry_ctrl.sv
// Keypad access controller: collects DIGITS digits, compares to code_val,
// drives grant/deny/lockout. Ports: digit_in, enter/clear pulses, status outs.
module code_entry_ctrl
    import code_entry_ctrl_pkg::*;
#(
    parameter int DIGITS         = DEF_DIGITS,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT,
    parameter int HOLD_CYCLES    = DEF_HOLD,
    parameter int MAX_FAIL       = DEF_MAX_FAIL,
    parameter int LOCK_CYCLES    = DEF_LOCK
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DIGIT_W-1:0]        digit_in,
    input  logic                      enter_pulse,
    input  logic                      clear_pulse,
    input  logic [DIGIT_W*DIGITS-1:0] code_val,
    output logic                      access_ok,
    output logic                      access_denied,
    output logic                      locked,
    output logic                      busy,
    output logic [2:0]                digit_count
);

    localparam int CW   = DIGIT_W * DIGITS;
    localparam int TMAX = max3(TIMEOUT_CYCLES, HOLD_CYCLES, LOCK_CYCLES);
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAIL + 1);

    localparam logic [2:0]    DIG_N    = 3'(DIGITS);
    localparam logic [FW-1:0] FAIL_MAX = FW'(MAX_FAIL);
    // GRANT/DENY/LOCKOUT leave when the timer reaches 0, so the load is
    // one less than the number of cycles the state must last.
    localparam logic [TW-1:0] T_TIMEOUT = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] T_HOLD    = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] T_LOCK    = TW'(LOCK_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] entry_q, entry_d;
    logic [2:0]    cnt_q, cnt_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [FW-1:0] fail_inc;
    logic [CW-1:0] entry_shift;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic [TW-1:0] tmr_value;
    logic          tmr_expired;

    code_entry_ctrl_cycle_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .value_o    (tmr_value),
        .expired_o  (tmr_expired)
    );

    assign entry_shift = {entry_q[CW-DIGIT_W-1:0], digit_in};
    assign fail_inc    = (fail_q == FAIL_MAX) ? fail_q : fail_q + FW'(1);

    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        cnt_d        = cnt_q;
        fail_d       = fail_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (enter_pulse) begin
                    entry_d      = entry_shift;
                    cnt_d        = 3'd1;
                    tmr_load     = 1'b1;
                    tmr_load_val = T_TIMEOUT;
                    state_d      = (DIG_N == 3'd1) ? ST_CHECK : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (clear_pulse) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (enter_pulse) begin
                    entry_d      = entry_shift;
                    cnt_d        = cnt_q + 3'd1;
                    tmr_load     = 1'b1;
                    tmr_load_val = T_TIMEOUT;
                    if (cnt_q + 3'd1 == DIG_N) begin
                        state_d = ST_CHECK;
                    end
                end else if (tmr_value == '0) begin
                    // abandoned entry; not a failure
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                cnt_d    = '0;
                tmr_load = 1'b1;
                if (entry_q == code_val) begin
                    fail_d       = '0;
                    tmr_load_val = T_HOLD;
                    state_d      = ST_GRANT;
                end else begin
                    fail_d = fail_inc;
                    if (fail_inc == FAIL_MAX) begin
                        tmr_load_val = T_LOCK;
                        state_d      = ST_LOCKOUT;
                    end else begin
                        tmr_load_val = T_HOLD;
                        state_d      = ST_DENY;
                    end
                end
            end
            ST_GRANT, ST_DENY: begin
                cnt_d = '0;
                if (tmr_expired) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCKOUT: begin
                cnt_d = '0;
                if (tmr_expired) begin
                    fail_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            entry_q <= '0;
            cnt_q   <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            cnt_q   <= cnt_d;
            fail_q  <= fail_d;
        end
    end

    assign access_ok     = (state_q == ST_GRANT);
    assign access_denied = (state_q == ST_DENY);
    assign locked        = (state_q == ST_LOCKOUT);
    assign busy          = (state_q != ST_IDLE);
    assign digit_count   = cnt_q;

endmodule

// File: tb/tb_code_entry_ctrl.sv
// Directed bench for code_entry_ctrl with short durations.
// Observes {access_ok, access_denied, locked, busy, digit_count}.
module tb_code_entry_ctrl;

    logic        clk;
    logic        rst;
    logic [3:0]  digit_in;
    logic        enter_pulse;
    logic        clear_pulse;
    logic [15:0] code_val;
    logic        access_ok;
    logic        access_denied;
    logic        locked;
    logic        busy;
    logic [2:0]  digit_count;

    int n_tests;
    int n_fail;

    localparam logic [15:0] GOOD = 16'h1234;
    localparam logic [15:0] BAD  = 16'h1235;

    localparam logic [6:0] O_IDLE  = 7'b0000_000;
    localparam logic [6:0] O_CHECK = 7'b0001_100;
    localparam logic [6:0] O_GRANT = 7'b1001_000;
    localparam logic [6:0] O_DENY  = 7'b0101_000;
    localparam logic [6:0] O_LOCK  = 7'b0011_000;

    code_entry_ctrl #(
        .DIGITS         (4),
        .TIMEOUT_CYCLES (20),
        .HOLD_CYCLES    (5),
        .MAX_FAIL       (3),
        .LOCK_CYCLES    (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .digit_in      (digit_in),
        .enter_pulse   (enter_pulse),
        .clear_pulse   (clear_pulse),
        .code_val      (code_val),
        .access_ok     (access_ok),
        .access_denied (access_denied),
        .locked        (locked),
        .busy          (busy),
        .digit_count   (digit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {access_ok, access_denied, locked, busy, digit_count};
    endfunction

    task automatic chk(input string tag, input logic [6:0] got,
                       input logic [6:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_in    = d;
        enter_pulse = 1'b1;
        tick();
        enter_pulse = 1'b0;
    endtask

    // Four digits spaced 3 cycles apart; returns on the CHECK cycle.
    task automatic enter_code(input logic [15:0] c);
        logic [15:0] v;
        v = c;
        for (int i = 0; i < 4; i++) begin
            key(v[15-4*i -: 4]);
            chk("count", obs(), {4'b0001, 3'(i + 1)});
            if (i < 3) begin
                tick();
                tick();
            end
        end
    endtask

    // From the CHECK cycle: verify outcome state for its full duration.
    task automatic result(input logic [6:0] exp, input int dur,
                          input bit poke);
        tick();
        for (int i = 0; i < dur; i++) begin
            chk("hold", obs(), exp);
            if (poke) begin
                digit_in    = 4'h1;
                enter_pulse = 1'(i % 2);
            end
            tick();
        end
        enter_pulse = 1'b0;
        chk("after", obs(), O_IDLE);
    endtask

    task automatic run_code(input logic [15:0] c, input logic [6:0] exp,
                            input int dur, input bit poke);
        enter_code(c);
        result(exp, dur, poke);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b0;
        digit_in    = 4'h0;
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        code_val    = GOOD;
        tick();
        tick();
        chk("reset", obs(), O_IDLE);
        rst = 1'b1;
        tick();
        chk("idle", obs(), O_IDLE);

        clear_pulse = 1'b1;
        tick();
        clear_pulse = 1'b0;
        chk("idle_clear", obs(), O_IDLE);

        run_code(GOOD, O_GRANT, 5, 1'b0);

        run_code(BAD, O_DENY, 5, 1'b0);
        run_code(GOOD, O_GRANT, 5, 1'b0);

        run_code(BAD, O_DENY, 5, 1'b0);
        run_code(BAD, O_DENY, 5, 1'b0);
        run_code(BAD, O_LOCK, 10, 1'b1);
        run_code(GOOD, O_GRANT, 5, 1'b0);

        // timeout between a deny and a second wrong code must not count
        run_code(BAD, O_DENY, 5, 1'b0);
        key(4'h1);
        tick();
        tick();
        key(4'h2);
        chk("to_cnt", obs(), 7'b0001_010);
        repeat (20) tick();
        chk("to_last", obs(), 7'b0001_010);
        tick();
        chk("to_idle", obs(), O_IDLE);
        run_code(BAD, O_DENY, 5, 1'b0);
        run_code(GOOD, O_GRANT, 5, 1'b0);

        // enter on the expiry cycle is accepted
        key(4'h1);
        repeat (20) tick();
        chk("exp_last", obs(), 7'b0001_001);
        key(4'h2);
        chk("exp_take", obs(), 7'b0001_010);
        tick();
        tick();
        key(4'h3);
        tick();
        tick();
        key(4'h4);
        chk("exp_check", obs(), O_CHECK);
        result(O_GRANT, 5, 1'b0);

        // enter and clear together: clear wins
        key(4'h1);
        digit_in    = 4'h2;
        enter_pulse = 1'b1;
        clear_pulse = 1'b1;
        tick();
        enter_pulse = 1'b0;
        clear_pulse = 1'b0;
        chk("collide", obs(), O_IDLE);
        tick();
        chk("collide2", obs(), O_IDLE);

        // reset in the middle of a lockout
        run_code(BAD, O_DENY, 5, 1'b0);
        run_code(BAD, O_DENY, 5, 1'b0);
        enter_code(BAD);
        tick();
        chk("lock_in", obs(), O_LOCK);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_mid", obs(), O_IDLE);
        rst = 1'b1;
        tick();
        chk("rst_rel", obs(), O_IDLE);
        run_code(BAD, O_DENY, 5, 1'b0);
        run_code(GOOD, O_GRANT, 5, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
